// File: rtl/tcdm_sram_bank.sv
// One TCDM bank in front of a single-port SRAM: address decode, out-of-range
// error responses, fixed-latency response pipeline and a zero-fill scrubber.
module tcdm_sram_bank #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NB_WORDS       = 16384,
   parameter logic [31:0] BASE_ADDR      = 32'h1C01_0000,
   parameter int unsigned INTL_BITS      = 2,
   parameter int unsigned SRAM_LATENCY   = 1,
   parameter bit          SCRUB_ON_RESET = 1'b1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   // TCDM slave port
   input  logic                          req_i,
   input  logic [31:0]                   add_i,
   input  logic                          wen_i,
   input  logic [DATA_WIDTH/8-1:0]       be_i,
   input  logic [DATA_WIDTH-1:0]         wdata_i,
   output logic                          gnt_o,
   output logic                          r_valid_o,
   output logic [DATA_WIDTH-1:0]         r_rdata_o,
   output logic                          r_opc_o,
   // SRAM macro port
   output logic                          sram_csn_o,
   output logic                          sram_wen_o,
   output logic [DATA_WIDTH/8-1:0]       sram_be_o,
   output logic [$clog2(NB_WORDS)-1:0]   sram_addr_o,
   output logic [DATA_WIDTH-1:0]         sram_wdata_o,
   input  logic [DATA_WIDTH-1:0]         sram_rdata_i,
   // control / status
   input  logic                          init_req_i,
   output logic                          busy_o,
   output logic [15:0]                   err_cnt_o,
   output logic [1:0]                    state_o
);

   localparam int unsigned AW = $clog2(NB_WORDS);

   // Handshake: a request is consumed in the cycle where req_i && gnt_o;
   // its single response appears SRAM_LATENCY cycles later as r_valid_o.
   typedef enum logic [1:0] {SCRUB = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

   state_e                  state_q, state_d;
   logic [AW-1:0]           cnt_q, cnt_d;
   logic [15:0]             err_cnt_q, err_cnt_d;
   logic [SRAM_LATENCY-1:0] vld_q, rd_q, err_q;
   logic [31:0]             offset, index;
   logic                    in_range;

   assign offset   = add_i - BASE_ADDR;
   assign index    = offset >> (2 + INTL_BITS);
   assign in_range = index < 32'(NB_WORDS);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gnt_o        = 1'b0;
      busy_o       = 1'b1;
      sram_csn_o   = 1'b1;
      sram_wen_o   = 1'b1;
      sram_be_o    = '0;
      sram_addr_o  = index[AW-1:0];
      sram_wdata_o = '0;
      unique case (state_q)
         SCRUB: begin
            sram_csn_o  = 1'b0;
            sram_wen_o  = 1'b0;
            sram_be_o   = '1;
            sram_addr_o = cnt_q;
            if (cnt_q == AW'(NB_WORDS - 1)) begin
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         RUN: begin
            busy_o = 1'b0;
            gnt_o  = req_i;
            if (req_i && in_range) begin
               sram_csn_o   = 1'b0;
               sram_wen_o   = wen_i;
               sram_be_o    = be_i;
               sram_wdata_o = wdata_i;
            end
            if (init_req_i) state_d = DRAIN;
         end
         DRAIN: begin
            // no new grants here, so the pipeline empties within SRAM_LATENCY cycles
            if (vld_q == '0) state_d = SCRUB;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (gnt_o && !in_range && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= SCRUB_ON_RESET ? SCRUB : RUN;
         cnt_q     <= '0;
         err_cnt_q <= '0;
         vld_q     <= '0;
         rd_q      <= '0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
         vld_q[0]  <= gnt_o;
         rd_q[0]   <= wen_i;
         err_q[0]  <= !in_range;
         for (int i = 1; i < SRAM_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            rd_q[i]  <= rd_q[i-1];
            err_q[i] <= err_q[i-1];
         end
      end
   end

   assign r_valid_o = vld_q[SRAM_LATENCY-1];
   assign r_opc_o   = vld_q[SRAM_LATENCY-1] & err_q[SRAM_LATENCY-1];
   assign r_rdata_o = (vld_q[SRAM_LATENCY-1] && rd_q[SRAM_LATENCY-1] && !err_q[SRAM_LATENCY-1])
                      ? sram_rdata_i : '0;
   assign err_cnt_o = err_cnt_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_tcdm_sram_bank.sv
// Directed + randomized bench for tcdm_sram_bank with a behavioural SRAM and a
// transaction-level reference model (timeline arithmetic, word array, response queue).
module tb_tcdm_sram_bank;

   localparam int          DW   = 32;
   localparam int          NB   = 16;
   localparam int          L    = 3;
   localparam int          INTL = 2;
   localparam logic [31:0] BASE = 32'h1C01_0000;

   // ---------------- clock / reset / DUT ----------------
   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          req_i, wen_i, init_req_i;
   logic [31:0]   add_i;
   logic [3:0]    be_i;
   logic [DW-1:0] wdata_i;
   logic          gnt_o, r_valid_o, r_opc_o, busy_o;
   logic [DW-1:0] r_rdata_o;
   logic          sram_csn_o, sram_wen_o;
   logic [3:0]    sram_be_o;
   logic [3:0]    sram_addr_o;
   logic [DW-1:0] sram_wdata_o, sram_rdata_i;
   logic [15:0]   err_cnt_o;
   logic [1:0]    state_o;

   always #5 clk_i = ~clk_i;

   tcdm_sram_bank #(
      .DATA_WIDTH(DW), .NB_WORDS(NB), .BASE_ADDR(BASE), .INTL_BITS(INTL),
      .SRAM_LATENCY(L), .SCRUB_ON_RESET(1'b1)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .wdata_i(wdata_i),
      .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
      .sram_csn_o(sram_csn_o), .sram_wen_o(sram_wen_o), .sram_be_o(sram_be_o),
      .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
      .init_req_i(init_req_i), .busy_o(busy_o), .err_cnt_o(err_cnt_o), .state_o(state_o)
   );

   // ---------------- behavioural SRAM (fixed read latency L) ----------------
   logic [DW-1:0] sram_mem [NB];
   logic [DW-1:0] rd_pipe  [L];

   always @(posedge clk_i) begin
      if (!sram_csn_o && !sram_wen_o)
         for (int b = 0; b < 4; b++)
            if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
      rd_pipe[0] <= (!sram_csn_o && sram_wen_o) ? sram_mem[sram_addr_o] : $urandom;
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign sram_rdata_i = rd_pipe[L-1];

   // ---------------- reference model state / scoreboard ----------------
   typedef struct {
      int            due;
      logic          err;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          exp_q[$];
   logic [DW-1:0] ref_mem [NB];
   logic [15:0]   m_err;
   int            cyc, scrub_start, run_from;
   int            checks, errors;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic do_reset(input int n);
      rst_ni = 1'b0; req_i = 1'b0; init_req_i = 1'b0; wen_i = 1'b1;
      add_i = '0; be_i = '0; wdata_i = '0;
      repeat (n) @(posedge clk_i);
      #1;
      rst_ni      = 1'b1;
      cyc         = cyc + n;
      scrub_start = cyc;
      run_from    = cyc + NB;
      m_err       = '0;
      exp_q.delete();
      for (int i = 0; i < NB; i++) ref_mem[i] = '0;
   endtask

   // One bus cycle: apply inputs, check at negedge, advance model, cross posedge.
   task automatic step(input logic req, input logic [31:0] addr, input logic wen,
                       input logic [3:0] be, input logic [DW-1:0] wdata, input logic init);
      logic [31:0] idx;
      logic        inr, run, scr;
      int          d_last;
      rsp_t        r;
      req_i = req; add_i = addr; wen_i = wen; be_i = be; wdata_i = wdata; init_req_i = init;
      idx = (addr - BASE) >> (2 + INTL);
      inr = idx < NB;
      run = cyc >= run_from;
      scr = (cyc >= scrub_start) && (cyc < run_from);
      @(negedge clk_i);
      chk("busy", busy_o, !run);
      chk("gnt", gnt_o, req && run);
      if (scr) begin
         chk("scrub_csn", sram_csn_o, 1'b0);
         chk("scrub_wen", sram_wen_o, 1'b0);
         chk("scrub_be", sram_be_o, 4'hF);
         chk("scrub_addr", sram_addr_o, 32'(cyc - scrub_start));
         chk("scrub_wdata", sram_wdata_o, '0);
      end else if (run && req && inr) begin
         chk("csn", sram_csn_o, 1'b0);
         chk("addr", sram_addr_o, idx[3:0]);
         chk("wen", sram_wen_o, wen);
         chk("be", sram_be_o, be);
         chk("wdata", sram_wdata_o, wdata);
      end else begin
         chk("csn_idle", sram_csn_o, 1'b1);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         r = exp_q.pop_front();
         chk("r_valid", r_valid_o, 1'b1);
         chk("r_rdata", r_rdata_o, r.data);
         chk("r_opc", r_opc_o, r.err);
      end else begin
         chk("r_valid_idle", r_valid_o, 1'b0);
         chk("r_rdata_idle", r_rdata_o, '0);
      end
      chk("err_cnt", err_cnt_o, m_err);
      if (run && req) begin
         r.due  = cyc + L;
         r.err  = !inr;
         r.data = (!inr || !wen) ? '0 : ref_mem[idx[3:0]];
         exp_q.push_back(r);
         if (!inr) begin
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
         end else if (!wen) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[idx[3:0]][b*8 +: 8] = wdata[b*8 +: 8];
         end
      end
      if (run && init) begin
         d_last      = (exp_q.size() > 0) ? exp_q[$].due : cyc;
         scrub_start = (d_last > cyc) ? d_last + 2 : cyc + 2;
         run_from    = scrub_start + NB;
         for (int i = 0; i < NB; i++) ref_mem[i] = '0;
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, BASE, 1'b1, 4'h0, '0, 1'b0);
   endtask

   task automatic rand_ops(input int n);
      logic [31:0] a;
      int          sel;
      for (int k = 0; k < n; k++) begin
         sel = $urandom_range(0, 9);
         if (sel < 7)       a = BASE + ($urandom_range(0, NB-1) << 4) + $urandom_range(0, 15);
         else if (sel == 7) a = BASE - $urandom_range(1, 4096);
         else if (sel == 8) a = BASE + (NB << 4) + $urandom_range(0, 1000);
         else               a = $urandom;
         step($urandom_range(0, 3) != 0, a, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), $urandom, 1'b0);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      checks = 0; errors = 0; cyc = 0;
      scrub_start = 0; run_from = 0; m_err = '0;
      do_reset(3);

      // reset scrub; a held read must wait, init during scrub is ignored
      for (int i = 0; i < NB + 3; i++) step(1'b1, BASE, 1'b1, 4'hF, '0, i == 3);
      idle(L + 1);
      for (int k = 0; k < NB; k++) chk("scrub_zero", sram_mem[k], '0);

      // write then read 0x1C01_0010 back-to-back
      step(1'b1, 32'h1C01_0010, 1'b0, 4'hF, 32'hA5A5_1234, 1'b0);
      step(1'b1, 32'h1C01_0010, 1'b1, 4'hF, '0, 1'b0);
      idle(L + 1);

      // out-of-range reads below base and just past the top
      step(1'b1, BASE - 32'd4, 1'b1, 4'hF, '0, 1'b0);
      step(1'b1, BASE + (NB << 4), 1'b1, 4'hF, '0, 1'b0);
      idle(L + 1);

      rand_ops(300);

      // init with two reads in flight
      step(1'b1, BASE + 32'h20, 1'b1, 4'hF, '0, 1'b0);
      step(1'b1, BASE + 32'h34, 1'b1, 4'hF, '0, 1'b1);
      step(1'b1, BASE + 32'h40, 1'b1, 4'hF, '0, 1'b0);
      idle(L + NB + 4);
      rand_ops(60);

      // reset with responses in flight discards them
      step(1'b1, BASE + 32'h10, 1'b1, 4'hF, '0, 1'b0);
      step(1'b1, BASE + 32'h50, 1'b1, 4'hF, '0, 1'b0);
      do_reset(1);
      while (cyc < scrub_start + 7) idle(1);
      do_reset(1);
      idle(NB + L + 2);
      rand_ops(40);

      // drive the error counter to saturation
      for (int i = 0; i < 65534 + 3; i++) step(1'b1, BASE - 32'd4, 1'b1, 4'hF, '0, 1'b0);
      idle(L + 2);
      chk("err_sat", err_cnt_o, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tcdm_sram_bank.md
TCDM_SRAM_BANK -- requirements
Module: tcdm_sram_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, TCDM/SRAM data width; multiple of 8.
REQ-002 SHALL have parameter NB_WORDS, default 16384, bank depth in DATA_WIDTH words; power of two.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1C01_0000, byte address subtracted from add_i.
REQ-004 SHALL have parameter INTL_BITS, default 2, number of bank-select address bits dropped above the byte offset; 0 means a private, non-interleaved bank.
REQ-005 SHALL have parameter SRAM_LATENCY, default 1, SRAM read latency in cycles; legal range 1..4.
REQ-006 SHALL have parameter SCRUB_ON_RESET, default 1; 1 means zero-fill the memory after reset.
REQ-007 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, synchronous, active-low; one clock, all logic on its rising edge.
REQ-008 SHALL have TCDM ports: req_i in 1; add_i in 32 byte address; wen_i in 1 (1=read, 0=write); be_i in DATA_WIDTH/8; wdata_i in DATA_WIDTH; gnt_o out 1; r_valid_o out 1; r_rdata_o out DATA_WIDTH; r_opc_o out 1 error flag.
REQ-009 SHALL have SRAM ports: sram_csn_o out 1 active-low; sram_wen_o out 1 (1=read); sram_be_o out DATA_WIDTH/8; sram_addr_o out $clog2(NB_WORDS); sram_wdata_o out DATA_WIDTH; sram_rdata_i in DATA_WIDTH, valid SRAM_LATENCY cycles after a read select.
REQ-010 SHALL have control ports: init_req_i in 1 scrub request pulse; busy_o out 1 scrub in progress; err_cnt_o out 16 count of out-of-range accesses.

Function
REQ-011 SHALL implement FSM states SCRUB, RUN, DRAIN.
REQ-012 In RUN, SHALL assert gnt_o = req_i combinationally, giving one access per cycle.
REQ-013 SHALL compute offset = add_i - BASE_ADDR mod 2^32 and index = offset >> (2+INTL_BITS), ignoring add_i[1:0] and bank-select bits.
REQ-014 An access with index < NB_WORDS SHALL drive sram_csn_o=0 in the grant cycle, with sram_addr_o=index[$clog2(NB_WORDS)-1:0] and be/wen/wdata passed through.
REQ-015 An access with index >= NB_WORDS (including addresses below BASE_ADDR) SHALL be granted without an SRAM access (sram_csn_o=1) and SHALL increment err_cnt_o, saturating at 16'hFFFF.
REQ-016 Every granted access SHALL produce exactly one r_valid_o pulse, SRAM_LATENCY cycles after the grant cycle, in grant order; the path is a valid/read/error shift pipeline of depth SRAM_LATENCY.
REQ-017 On a valid read response, r_rdata_o SHALL equal sram_rdata_i and r_opc_o SHALL be 0.
REQ-018 On a write response, r_rdata_o SHALL be 0 and r_opc_o SHALL be 0.
REQ-019 On an error response, r_rdata_o SHALL be 0 and r_opc_o SHALL be 1.
REQ-020 When r_valid_o=0, r_rdata_o SHALL be 0.
REQ-021 init_req_i=1 in RUN SHALL move the FSM to DRAIN on the next edge; from that cycle gnt_o=0.
REQ-022 In DRAIN, SHALL stay until the response pipeline is empty, then enter SCRUB; outstanding responses are still delivered.
REQ-023 In SCRUB, SHALL write one word per cycle with sram_csn_o=0, sram_wen_o=0, sram_be_o all ones, sram_wdata_o=0, and address counter 0..NB_WORDS-1.
REQ-024 In SCRUB, gnt_o SHALL be 0 and busy_o SHALL be 1; after writing address NB_WORDS-1, the FSM SHALL enter RUN next cycle and the counter SHALL return to 0.
REQ-025 busy_o SHALL be 1 in DRAIN and SCRUB, and 0 in RUN.
REQ-026 init_req_i SHALL be ignored in DRAIN and SCRUB.
REQ-027 err_cnt_o SHALL be cleared only by reset; a scrub SHALL NOT clear it.
REQ-028 req_i while gnt_o=0 SHALL NOT be consumed; the master holds the request.

Reset
REQ-029 While rst_ni=0 at a rising edge: FSM <= SCRUB if SCRUB_ON_RESET=1, else RUN.
REQ-030 While rst_ni=0 at a rising edge: scrub counter <= 0, response pipeline cleared, err_cnt_o <= 0.
REQ-031 Resulting output values after reset: r_valid_o=0, r_opc_o=0, r_rdata_o=0; sram_csn_o=1 except while scrubbing.
REQ-032 Reset asserted mid-scrub or with responses in flight SHALL discard them; no r_valid_o pulse follows for them.
REQ-033 The block is usable only after busy_o=0.

Verification
REQ-034 Reset with SCRUB_ON_RESET=1, NB_WORDS=16 -> busy_o=1 for exactly 16 cycles, sram addresses 0..15 written with zero, then gnt_o follows req_i.
REQ-035 SRAM_LATENCY=3, back-to-back write to 0x1C01_0010 then read of it every cycle (INTL_BITS=2) -> sram_addr_o=1 both cycles, r_valid_o 3 cycles after each grant, read returns written data, r_opc_o=0.
REQ-036 Read of BASE_ADDR-4 and of BASE_ADDR+(NB_WORDS<<4) -> no SRAM select, r_opc_o=1, r_rdata_o=0, err_cnt_o increments by 2.
REQ-037 init_req_i with 2 reads in flight (SRAM_LATENCY=2) -> both responses delivered, gnt_o=0 from next cycle, scrub starts after drain, busy_o drops after NB_WORDS scrub cycles.
REQ-038 err_cnt_o preloaded to 16'hFFFE by driving errors, then 3 more errors -> err_cnt_o holds 16'hFFFF.
REQ-039 rst_ni=0 for one cycle during scrub at address 7 with SRAM_LATENCY=2 -> scrub restarts at 0 and no stale r_valid_o is seen.
